// File: rtl/bcd2bin_seq_pkg.sv
// Shared constants, state encoding and digit helpers for the BCD-to-binary converter.
package bcd2bin_seq_pkg;

    localparam int unsigned BCD_DIGIT_W   = 4;
    localparam int unsigned BCD_MAX_DIGIT = 9;

    localparam logic [1:0] STATE_IDLE = 2'd0;
    localparam logic [1:0] STATE_CONV = 2'd1;
    localparam logic [1:0] STATE_DONE = 2'd2;

    typedef enum logic [1:0] {
        StIdle = STATE_IDLE,
        StConv = STATE_CONV,
        StDone = STATE_DONE
    } state_e;

    // True when a single BCD digit holds a non-decimal code (10..15).
    function automatic logic digit_invalid(input logic [BCD_DIGIT_W-1:0] digit);
        return digit > BCD_DIGIT_W'(BCD_MAX_DIGIT);
    endfunction

endpackage

// File: rtl/bcd2bin_seq_if.sv
// Start/done handshake bundle between operand entry logic and the converter.
interface bcd2bin_seq_if
    import bcd2bin_seq_pkg::*;
#(
    parameter int unsigned N_DIGITS = 4,
    parameter int unsigned BIN_W    = 14
);

    logic                            start;
    logic [N_DIGITS*BCD_DIGIT_W-1:0] bcd;
    logic [BIN_W-1:0]                bin;
    logic                            busy;
    logic                            done;
    logic                            err;

    modport master (
        output start, bcd,
        input  bin, busy, done, err
    );

    modport slave (
        input  start, bcd,
        output bin, busy, done, err
    );

endinterface

// File: rtl/bcd2bin_seq_adjust.sv
// Reverse double-dabble digit correction: subtract 3 from any digit that is 8 or more.
module bcd_digit_adjust
    import bcd2bin_seq_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit,
    output logic [BCD_DIGIT_W-1:0] adjusted
);

    // After a right shift a digit >= 8 carries a weight of 5 that belongs to the lower digit.
    always_comb begin
        adjusted = digit;
        if (digit >= BCD_DIGIT_W'(8)) begin
            adjusted = digit - BCD_DIGIT_W'(3);
        end
    end

endmodule

// File: rtl/bcd2bin_seq.sv
// Multi-cycle BCD-to-binary converter: one shift-and-correct step per clock.
module bcd2bin_seq
    import bcd2bin_seq_pkg::*;
#(
    parameter int unsigned N_DIGITS = 4,
    parameter int unsigned BIN_W    = 14
) (
    input logic          clk,
    input logic          reset,
    bcd2bin_seq_if.slave bus
);

    localparam int unsigned BCD_W = N_DIGITS * BCD_DIGIT_W;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BCD_W-1:0]   bcd_work_q, bcd_work_d;
    logic [BIN_W-1:0]   bin_work_q, bin_work_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic               err_q, err_d;

    logic [BCD_W-1:0]   bcd_shift;
    logic [BCD_W-1:0]   bcd_adj;
    logic [BIN_W-1:0]   bin_shift;
    logic               bcd_invalid;

    // The BCD LSB falls into the binary MSB as the concatenation shifts right.
    assign bcd_shift = bcd_work_q >> 1;
    assign bin_shift = {bcd_work_q[0], bin_work_q[BIN_W-1:1]};

    for (genvar i = 0; i < N_DIGITS; i++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit    (bcd_shift[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .adjusted (bcd_adj[i*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // Flag any non-decimal digit on the incoming operand.
    always_comb begin
        bcd_invalid = 1'b0;
        for (int i = 0; i < int'(N_DIGITS); i++) begin
            if (digit_invalid(bus.bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W])) begin
                bcd_invalid = 1'b1;
            end
        end
    end

    // Next-state logic; bin/err are only loaded on the transition into DONE.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bcd_work_d = bcd_work_q;
        bin_work_d = bin_work_q;
        bin_d      = bin_q;
        err_d      = err_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    bcd_work_d = bus.bcd;
                    bin_work_d = '0;
                    cnt_d      = CNT_W'(BIN_W);
                    if (bcd_invalid) begin
                        state_d = StDone;
                        bin_d   = '0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = StConv;
                    end
                end
            end
            StConv: begin
                bcd_work_d = bcd_adj;
                bin_work_d = bin_shift;
                cnt_d      = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = StDone;
                    bin_d   = bin_shift;
                    err_d   = 1'b0;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            bcd_work_q <= '0;
            bin_work_q <= '0;
            bin_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bcd_work_q <= bcd_work_d;
            bin_work_q <= bin_work_d;
            bin_q      <= bin_d;
            err_q      <= err_d;
        end
    end

    assign bus.bin  = bin_q;
    assign bus.err  = err_q;
    assign bus.busy = (state_q == StConv);
    assign bus.done = (state_q == StDone);

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Directed and randomized checks of bcd2bin_seq against an arithmetic decimal model.
module tb_bcd2bin_seq;

    localparam int unsigned N_DIGITS = 4;
    localparam int unsigned BIN_W    = 14;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_err;
    logic [BIN_W-1:0] held_bin;

    bcd2bin_seq_if #(.N_DIGITS(N_DIGITS), .BIN_W(BIN_W)) bus ();

    bcd2bin_seq #(.N_DIGITS(N_DIGITS), .BIN_W(BIN_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Decimal meaning of the packed digits, most significant digit first.
    function automatic void model(input logic [15:0] v, output logic [BIN_W-1:0] b,
                                  output logic e);
        int acc;
        int d;
        acc = 0;
        e   = 1'b0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            d = int'(v[i*4 +: 4]);
            if (d > 9) e = 1'b1;
            acc = acc * 10 + d;
        end
        b = e ? '0 : BIN_W'(acc);
    endfunction

    // Full transaction; returns in the cycle after done with start low.
    task automatic run_conv(input logic [15:0] v, input int mid_at, input logic [15:0] mid_v);
        logic [BIN_W-1:0] eb;
        logic             ee;
        int               n;
        int               nbusy;
        model(v, eb, ee);
        bus.start = 1'b1;
        bus.bcd   = v;
        tick();
        bus.start = 1'b0;
        bus.bcd   = 16'($urandom);
        if (!ee) check("bin_held_during_conv", 32'(bus.bin), 32'(held_bin));
        n     = 0;
        nbusy = 0;
        while (!bus.done && n < 40) begin
            if (bus.busy) nbusy++;
            if (n == mid_at) begin
                bus.start = 1'b1;
                bus.bcd   = mid_v;
            end else begin
                bus.start = 1'b0;
            end
            tick();
            n++;
        end
        bus.start = 1'b0;
        check("latency", 32'(n), ee ? 32'd0 : 32'(BIN_W));
        check("busy_cycles", 32'(nbusy), ee ? 32'd0 : 32'(BIN_W));
        check("done", 32'(bus.done), 32'd1);
        check("busy_at_done", 32'(bus.busy), 32'd0);
        check("bin", 32'(bus.bin), 32'(eb));
        check("err", 32'(bus.err), 32'(ee));
        tick();
        check("done_single_pulse", 32'(bus.done), 32'd0);
        check("bin_hold_after_done", 32'(bus.bin), 32'(eb));
        held_bin = eb;
    endtask

    initial begin
        logic [15:0] v;
        int          dones;
        n_checks  = 0;
        n_err     = 0;
        held_bin  = '0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.bcd   = '0;
        repeat (3) tick();
        bus.start = 1'b1;
        bus.bcd   = 16'h1234;
        tick();
        check("reset_bin", 32'(bus.bin), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_err", 32'(bus.err), 32'd0);
        bus.start = 1'b0;
        reset     = 1'b0;
        tick();

        run_conv(16'h0000, -1, 16'h0);
        run_conv(16'h1234, -1, 16'h0);
        run_conv(16'h9999, -1, 16'h0);
        run_conv(16'h0001, -1, 16'h0);
        run_conv(16'h12A4, -1, 16'h0);
        run_conv(16'h0042, -1, 16'h0);

        // Start pulsed mid-conversion must be neither honoured nor queued.
        run_conv(16'h2468, 5, 16'h1111);
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done) dones++;
            tick();
        end
        check("no_queued_start", 32'(dones), 32'd0);

        // Reset in the middle of a conversion aborts it.
        bus.start = 1'b1;
        bus.bcd   = 16'h7777;
        tick();
        bus.start = 1'b0;
        repeat (6) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_bin", 32'(bus.bin), 32'd0);
        check("abort_err", 32'(bus.err), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done) dones++;
            tick();
        end
        check("abort_no_done", 32'(dones), 32'd0);
        held_bin = '0;
        run_conv(16'h0500, -1, 16'h0);

        // Random operands, occasionally with a non-decimal digit.
        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                if ($urandom_range(0, 9) == 0) v[i*4 +: 4] = 4'($urandom_range(10, 15));
                else v[i*4 +: 4] = 4'($urandom_range(0, 9));
            end
            run_conv(v, -1, 16'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/bcd2bin_seq.md
Name: bcd2bin_seq

Overview:
- Multi-cycle BCD-to-binary converter. It is the inverse of the team's combinational binary-to-BCD path.
- Converts N_DIGITS packed BCD digits (e.g. keypad/display entry, 0..9999) into an unsigned binary value, using iterative reverse double-dabble: one shift-and-correct per clock.
- Sits between operand entry logic and the datapath, which consumes 14-bit binary operands.
- Uses a start/done handshake so one small adjust datapath is reused instead of a wide combinational chain.

Parameters:
- N_DIGITS, 4, number of packed BCD input digits.
- BIN_W, 14, output width and iteration count. Must satisfy 2^BIN_W > 10^N_DIGITS - 1.

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- reset, input, 1, synchronous active-high reset.
- start, input, 1, request conversion; sampled only in IDLE.
- bcd, input, 4*N_DIGITS, packed BCD; digit 0 is bits [3:0]. Captured on the accepted start.
- bin, output, BIN_W, binary result; held stable from done until the next accepted start.
- busy, output, 1, high from the cycle after an accepted start until done.
- done, output, 1, one-cycle pulse when bin/err are valid.
- err, output, 1, set with done if any captured digit > 9; held with bin.

Behaviour:
- Reset (synchronous, active-high, overrides everything): state=IDLE, bin=0, busy=0, done=0, err=0, iteration counter=0, working registers=0.
- States: IDLE, CONV, DONE.
- IDLE:
  - When start=1, capture bcd into the working BCD register, clear the working binary register, load counter=BIN_W, and clear err.
  - If any captured digit > 9, go to DONE with err pending. Otherwise go to CONV.
  - start=0 stays in IDLE.
- CONV: each cycle performs one step:
  1. Shift the {bcd_work, bin_work} concatenation right by 1; the bcd_work LSB enters the bin_work MSB.
  2. Then every 4-bit digit of bcd_work with value >= 8 has 3 subtracted (4-bit wrap-free by construction).
  3. Decrement the counter. When the counter reaches 1 during this step, go to DONE.
- DONE (one cycle): done=1, busy=0.
  - bin = bin_work, or bin = 0 if err. err = 1 if invalid digit, else 0.
  - Next state IDLE.
- Latency: start accepted at edge E0. CONV occupies BIN_W cycles, and done is high in cycle E0+BIN_W+1 (15 cycles for the default).
  - Invalid input: done at E0+1.
- start while busy or in DONE is ignored and is not queued.
- bin/err change only on entry to DONE or on reset; they are never observable mid-conversion.
- Back-to-back: start asserted in the cycle after done is accepted normally from IDLE.
- Reset mid-CONV aborts the conversion: no done pulse, outputs return to reset values.
- Boundary values:
  - bcd all zeros gives bin=0.
  - Maximum valid input 9999 gives 0x270F, with no overflow for the default parameters.
  - Leading-zero digits are legal.

Decomposition:
- Shared package/header: BCD_DIGIT_W=4, BCD_MAX_DIGIT=9, and the state encoding localparams (IDLE/CONV/DONE).
- One natural sub-module: bcd_digit_adjust (combinational, 4-bit in/out, subtracts 3 when the input is >= 8). It is instantiated N_DIGITS times. A sibling digit_valid check (> 9) can live in the same file.
- The FSM and counter stay in the top.

Test Plan:
- Reset, then start with bcd=16'h0000 -> done after 15 cycles, bin=0, err=0, busy high for exactly 14 cycles.
- bcd=16'h1234 -> bin=14'd1234 (0x4D2), err=0, done is a single-cycle pulse.
- bcd=16'h9999 -> bin=14'h270F, err=0. Then bcd=16'h0001 back-to-back in the cycle after done -> bin=1.
- bcd=16'h12A4 (invalid digit) -> done one cycle after start, err=1, bin=0. Then a valid 16'h0042 clears err and gives bin=42.
- start pulsed again mid-CONV with a different bcd -> ignored; the result matches the first operand, and only one done is seen.
- Assert reset at CONV cycle 7 -> no done. Outputs are 0 next cycle, and a fresh start converts 16'h0500 to 500 correctly.
